// File: rtl/calc_pkg.sv
// Shared definitions for the keypad calculator sequencing controller:
// operator codes, controller state encoding and key classification.
package calc_pkg;

  localparam int NDIG_DEFAULT = 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  localparam logic [2:0] S_A    = 3'd0;
  localparam logic [2:0] S_OP   = 3'd1;
  localparam logic [2:0] S_B    = 3'd2;
  localparam logic [2:0] S_CALC = 3'd3;
  localparam logic [2:0] S_RES  = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  typedef struct packed {
    logic clr;
    logic equals;
    logic oper;
    logic digit;
  } keyClassT;

  // One key event resolves to at most one class: CLR, equals, operator, digit.
  function automatic keyClassT decodeKey(input logic       pulse,
                                         input logic       number,
                                         input logic       operation,
                                         input logic       equals,
                                         input logic [3:0] digit,
                                         input logic [1:0] op);
    keyClassT k;
    logic     arith;
    arith    = (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
    k.clr    = pulse & operation & (op == OP_CLR);
    k.equals = pulse & equals & ~k.clr;
    k.oper   = pulse & operation & arith & ~equals;
    k.digit  = pulse & number & (digit <= 4'd9) & ~operation & ~equals;
    return k;
  endfunction

endpackage

// File: rtl/calc_ctrl_bcd_entry_reg.sv
// NDIG-digit BCD entry register: left-shifting digit entry that saturates
// after NDIG digits, plus clear, single-digit load and parallel load.
module bcd_entry_reg
  import calc_pkg::*;
#(
  parameter int NDIG = NDIG_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              shiftEn,
  input  logic              loadDigit,
  input  logic              loadAll,
  input  logic [3:0]        digit,
  input  logic [4*NDIG-1:0] loadValue,
  output logic [4*NDIG-1:0] value
);

  localparam int CW = $clog2(NDIG + 1);

  logic [CW-1:0] count;

  // A parallel load counts as a full entry so later digits cannot grow it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
      count <= '0;
    end else if (clear) begin
      value <= '0;
      count <= '0;
    end else if (loadAll) begin
      value <= loadValue;
      count <= CW'(NDIG);
    end else if (loadDigit) begin
      value <= {{(4*NDIG-4){1'b0}}, digit};
      count <= CW'(1);
    end else if (shiftEn && (count < CW'(NDIG))) begin
      value <= {value[4*NDIG-5:0], digit};
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/calc_ctrl.sv
// Calculator sequencer: builds operands A/B and the operator from key events,
// runs the ALU start/done handshake, latches the result and drives the display.
module calc_ctrl
  import calc_pkg::*;
#(
  parameter int NDIG = NDIG_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_pulse,
  input  logic              number_pressed,
  input  logic              operation_pressed,
  input  logic              equals_pressed,
  input  logic [3:0]        digit_in,
  input  logic [1:0]        op_in,
  input  logic              alu_done,
  input  logic              alu_err,
  input  logic              alu_neg,
  input  logic [8*NDIG-1:0] alu_result,
  output logic [4*NDIG-1:0] operand_a,
  output logic [4*NDIG-1:0] operand_b,
  output logic [1:0]        alu_op,
  output logic              alu_start,
  output logic              busy,
  output logic [8*NDIG-1:0] disp_bcd,
  output logic              disp_neg,
  output logic              disp_err
);

  localparam int W = 4 * NDIG;

  logic [2:0]     state, nextState;
  logic [2*W-1:0] result;
  logic           resultNeg;
  keyClassT       key;
  logic           doneSeen, chainOk, opLoad, startNext, resLoad;
  logic           aClear, aShift, aLoadDigit, aLoadAll;
  logic           bClear, bShift, bLoadDigit;

  assign key = decodeKey(key_pulse, number_pressed, operation_pressed,
                         equals_pressed, digit_in, op_in);

  // The ALU is only listened to once the start pulse has been retired.
  assign doneSeen = (state == S_CALC) & alu_done & ~alu_start;
  assign chainOk  = ~resultNeg & (result[2*W-1:W] == '0);
  assign busy     = (state == S_CALC);

  bcd_entry_reg #(.NDIG(NDIG)) regA (
    .clk       (clk),
    .rst       (rst),
    .clear     (aClear),
    .shiftEn   (aShift),
    .loadDigit (aLoadDigit),
    .loadAll   (aLoadAll),
    .digit     (digit_in),
    .loadValue (result[W-1:0]),
    .value     (operand_a)
  );

  bcd_entry_reg #(.NDIG(NDIG)) regB (
    .clk       (clk),
    .rst       (rst),
    .clear     (bClear),
    .shiftEn   (bShift),
    .loadDigit (bLoadDigit),
    .loadAll   (1'b0),
    .digit     (digit_in),
    .loadValue ({W{1'b0}}),
    .value     (operand_b)
  );

  // CLR overrides everything, including an alu_done arriving in the same cycle.
  always_comb begin
    nextState  = state;
    opLoad     = 1'b0;
    startNext  = 1'b0;
    resLoad    = 1'b0;
    aClear     = 1'b0;
    aShift     = 1'b0;
    aLoadDigit = 1'b0;
    aLoadAll   = 1'b0;
    bClear     = 1'b0;
    bShift     = 1'b0;
    bLoadDigit = 1'b0;
    if (key.clr) begin
      aClear    = 1'b1;
      bClear    = 1'b1;
      nextState = S_A;
    end else begin
      case (state)
        S_A: begin
          aShift = key.digit;
          if (key.oper) begin
            opLoad    = 1'b1;
            nextState = S_OP;
          end
        end
        S_OP: begin
          if (key.digit) begin
            bLoadDigit = 1'b1;
            nextState  = S_B;
          end else if (key.oper) begin
            opLoad = 1'b1;
          end
        end
        S_B: begin
          if (key.equals) begin
            startNext = 1'b1;
            nextState = S_CALC;
          end else begin
            bShift = key.digit;
          end
        end
        S_CALC: begin
          if (doneSeen) begin
            resLoad   = ~alu_err;
            nextState = alu_err ? S_ERR : S_RES;
          end
        end
        S_RES: begin
          if (key.digit) begin
            aLoadDigit = 1'b1;
            bClear     = 1'b1;
            nextState  = S_A;
          end else if (key.oper && chainOk) begin
            aLoadAll  = 1'b1;
            opLoad    = 1'b1;
            nextState = S_OP;
          end
        end
        S_ERR: begin
          nextState = S_ERR;
        end
        default: begin
          nextState = S_A;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_A;
      alu_start <= 1'b0;
      alu_op    <= OP_ADD;
      result    <= '0;
      resultNeg <= 1'b0;
    end else begin
      state     <= nextState;
      alu_start <= startNext;
      if (key.clr) begin
        alu_op <= OP_ADD;
      end else if (opLoad) begin
        alu_op <= op_in;
      end
      if (key.clr) begin
        result    <= '0;
        resultNeg <= 1'b0;
      end else if (resLoad) begin
        result    <= alu_result;
        resultNeg <= alu_neg;
      end
    end
  end

  always_comb begin
    disp_bcd = '0;
    disp_neg = 1'b0;
    disp_err = 1'b0;
    case (state)
      S_A, S_OP:   disp_bcd = {{W{1'b0}}, operand_a};
      S_B, S_CALC: disp_bcd = {{W{1'b0}}, operand_b};
      S_RES: begin
        disp_bcd = result;
        disp_neg = resultNeg;
      end
      S_ERR:       disp_err = 1'b1;
      default:     disp_bcd = '0;
    endcase
  end

endmodule

// File: tb/tb_calc_ctrl.sv
// Self-checking bench for calc_ctrl: a decimal-arithmetic reference model
// drives expectations; a monitor scoreboards every ALU start transaction.
module tb_calc_ctrl;

  localparam int NDIG = 4;
  localparam int W    = 4 * NDIG;

  logic           clk = 1'b0;
  logic           rst;
  logic           key_pulse, number_pressed, operation_pressed, equals_pressed;
  logic [3:0]     digit_in;
  logic [1:0]     op_in;
  logic           alu_done, alu_err, alu_neg;
  logic [2*W-1:0] alu_result;
  logic [W-1:0]   operand_a, operand_b;
  logic [1:0]     alu_op;
  logic           alu_start, busy;
  logic [2*W-1:0] disp_bcd;
  logic           disp_neg, disp_err;

  always #5 clk = ~clk;

  calc_ctrl #(.NDIG(NDIG)) dut (
    .clk               (clk),
    .rst               (rst),
    .key_pulse         (key_pulse),
    .number_pressed    (number_pressed),
    .operation_pressed (operation_pressed),
    .equals_pressed    (equals_pressed),
    .digit_in          (digit_in),
    .op_in             (op_in),
    .alu_done          (alu_done),
    .alu_err           (alu_err),
    .alu_neg           (alu_neg),
    .alu_result        (alu_result),
    .operand_a         (operand_a),
    .operand_b         (operand_b),
    .alu_op            (alu_op),
    .alu_start         (alu_start),
    .busy              (busy),
    .disp_bcd          (disp_bcd),
    .disp_neg          (disp_neg),
    .disp_err          (disp_err)
  );

  typedef enum int {PH_ENTER_A, PH_GOT_OP, PH_ENTER_B, PH_WAIT, PH_SHOW, PH_ERROR} phaseT;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
  } startT;

  // Reference model: operands and results kept as plain decimal integers.
  phaseT      phase;
  int         aVal, bVal, aCnt, bCnt, resVal, pendVal;
  bit         resNeg, pendNeg;
  logic [1:0] mOp;

  int    checks = 0;
  int    fails  = 0;
  startT expQ[$];
  startT held, popped;
  bit    haveHeld = 0;

  function automatic logic [2*W-1:0] toBcd(input int v);
    logic [2*W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 2 * NDIG; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void modelReset();
    phase  = PH_ENTER_A;
    aVal   = 0;
    bVal   = 0;
    aCnt   = 0;
    bCnt   = 0;
    resVal = 0;
    resNeg = 0;
    mOp    = 2'b00;
  endfunction

  function automatic void modelKey(input bit num, input bit opr, input bit eq,
                                   input logic [3:0] d, input logic [1:0] o);
    startT s;
    if (opr && o == 2'b11) begin
      modelReset();
      return;
    end
    if (phase == PH_WAIT || phase == PH_ERROR) return;
    if (eq) begin
      if (phase == PH_ENTER_B) begin
        s.a  = W'(toBcd(aVal));
        s.b  = W'(toBcd(bVal));
        s.op = mOp;
        expQ.push_back(s);
        pendNeg = 0;
        case (mOp)
          2'b00: pendVal = aVal + bVal;
          2'b01: begin
            pendVal = (aVal >= bVal) ? aVal - bVal : bVal - aVal;
            pendNeg = (aVal < bVal);
          end
          default: pendVal = aVal * bVal;
        endcase
        phase = PH_WAIT;
      end
      return;
    end
    if (opr) begin
      if (phase == PH_ENTER_A || phase == PH_GOT_OP) begin
        mOp   = o;
        phase = PH_GOT_OP;
      end else if (phase == PH_SHOW && !resNeg && resVal < 10 ** NDIG) begin
        aVal  = resVal;
        aCnt  = NDIG;
        mOp   = o;
        phase = PH_GOT_OP;
      end
      return;
    end
    if (num && d <= 9) begin
      case (phase)
        PH_ENTER_A: if (aCnt < NDIG) begin aVal = aVal * 10 + int'(d); aCnt++; end
        PH_GOT_OP:  begin bVal = int'(d); bCnt = 1; phase = PH_ENTER_B; end
        PH_ENTER_B: if (bCnt < NDIG) begin bVal = bVal * 10 + int'(d); bCnt++; end
        PH_SHOW:    begin aVal = int'(d); aCnt = 1; bVal = 0; bCnt = 0; phase = PH_ENTER_A; end
        default: ;
      endcase
    end
  endfunction

  task automatic checkOutput();
    logic [2*W-1:0] expBcd;
    bit expNeg, expErr;
    expBcd = '0;
    expNeg = 0;
    expErr = 0;
    case (phase)
      PH_ENTER_A, PH_GOT_OP: expBcd = toBcd(aVal);
      PH_ENTER_B, PH_WAIT:   expBcd = toBcd(bVal);
      PH_SHOW:  begin expBcd = toBcd(resVal); expNeg = resNeg; end
      default:  expErr = 1;
    endcase
    compare("disp_bcd", disp_bcd, expBcd);
    compare("disp_neg", disp_neg, expNeg);
    compare("disp_err", disp_err, expErr);
    compare("busy", busy, phase == PH_WAIT);
  endtask

  // Called on a falling edge; returns on the next falling edge with outputs checked.
  task automatic applyStimulus(input bit num, input bit opr, input bit eq,
                               input logic [3:0] d, input logic [1:0] o);
    key_pulse         = 1'b1;
    number_pressed    = num;
    operation_pressed = opr;
    equals_pressed    = eq;
    digit_in          = d;
    op_in             = o;
    modelKey(num, opr, eq, d, o);
    @(negedge clk);
    key_pulse         = 1'b0;
    number_pressed    = 1'b0;
    operation_pressed = 1'b0;
    equals_pressed    = 1'b0;
    digit_in          = 4'($urandom_range(0, 15));
    op_in             = 2'($urandom_range(0, 3));
    checkOutput();
  endtask

  task automatic digit(input int d);
    applyStimulus(1, 0, 0, 4'(d), 2'b00);
  endtask

  task automatic oper(input logic [1:0] o);
    applyStimulus(0, 1, 0, 4'd0, o);
  endtask

  task automatic sendDone(input bit err, input bit withClr);
    @(negedge clk);
    alu_done   = 1'b1;
    alu_err    = err;
    alu_neg    = pendNeg;
    alu_result = toBcd(pendVal);
    if (withClr) begin
      key_pulse         = 1'b1;
      operation_pressed = 1'b1;
      op_in             = 2'b11;
      modelReset();
    end else if (phase == PH_WAIT) begin
      if (err) phase = PH_ERROR;
      else begin
        resVal = pendVal;
        resNeg = pendNeg;
        phase  = PH_SHOW;
      end
    end
    @(negedge clk);
    alu_done          = 1'b0;
    alu_err           = 1'b0;
    key_pulse         = 1'b0;
    operation_pressed = 1'b0;
    alu_result        = {$urandom, $urandom};
    checkOutput();
  endtask

  task automatic randomKey();
    int r;
    logic [3:0] d;
    logic [1:0] o;
    r = $urandom_range(0, 99);
    d = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
    o = 2'($urandom_range(0, 2));
    if (r < 50)      applyStimulus(1, 0, 0, d, o);
    else if (r < 65) applyStimulus(0, 1, 0, d, o);
    else if (r < 77) applyStimulus(0, 0, 1, d, o);
    else if (r < 81) applyStimulus(0, 1, 0, d, 2'b11);
    else if (r < 86) applyStimulus(1, 0, 1, d, o);
    else if (r < 90) applyStimulus(1, 1, 0, d, o);
    else if (r < 94) applyStimulus(0, 1, 1, d, o);
    else             applyStimulus(0, 0, 0, d, o);
  endtask

  // Monitor: every start pulse must match the oldest expected transaction,
  // and the operands/operator must hold while the ALU is busy.
  always @(negedge clk) begin
    if (alu_start === 1'b1) begin
      if (expQ.size() == 0) begin
        compare("unexpected_alu_start", 1, 0);
      end else begin
        popped = expQ.pop_front();
        compare("start_operand_a", operand_a, popped.a);
        compare("start_operand_b", operand_b, popped.b);
        compare("start_alu_op", alu_op, popped.op);
        held     = popped;
        haveHeld = 1;
      end
    end else if (busy === 1'b1 && haveHeld) begin
      compare("hold_operand_a", operand_a, held.a);
      compare("hold_operand_b", operand_b, held.b);
      compare("hold_alu_op", alu_op, held.op);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    key_pulse = 0; number_pressed = 0; operation_pressed = 0; equals_pressed = 0;
    digit_in = 0; op_in = 0; alu_done = 0; alu_err = 0; alu_neg = 0; alu_result = '0;
    pendVal = 0; pendNeg = 0;
    modelReset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput();
    compare("reset_operand_a", operand_a, 0);
    compare("reset_operand_b", operand_b, 0);
    compare("reset_alu_op", alu_op, 0);
    compare("reset_alu_start", alu_start, 0);

    // 1, 2, ADD, 3, = then result 15
    digit(1); digit(2); oper(2'b00); digit(3);
    applyStimulus(0, 0, 1, 4'd0, 2'b00);
    compare("t1_start", alu_start, 1);
    compare("t1_operand_a", operand_a, 16'h0012);
    compare("t1_operand_b", operand_b, 16'h0003);
    sendDone(0, 0);
    compare("t1_disp", disp_bcd, 32'h0000_0015);

    // Chaining from 15: MUL, 2, =
    oper(2'b10); digit(2);
    applyStimulus(0, 0, 1, 4'd0, 2'b00);
    compare("chain_operand_a", operand_a, 16'h0015);
    compare("chain_alu_op", alu_op, 2'b10);
    sendDone(0, 0);

    // Saturation and equals ignored in S_A
    oper(2'b11);
    for (int i = 1; i <= 5; i++) digit(i);
    compare("sat_operand_a", operand_a, 16'h1234);
    applyStimulus(0, 0, 1, 4'd0, 2'b00);
    compare("eq_in_a_no_start", alu_start, 0);

    // Operator replaced in S_OP, ignored in S_B
    oper(2'b11); digit(7); oper(2'b00); oper(2'b01); digit(2); oper(2'b10);
    applyStimulus(0, 0, 1, 4'd0, 2'b00);
    compare("sub_alu_op", alu_op, 2'b01);
    sendDone(0, 0);
    compare("sub_disp_neg", disp_neg, 0);

    // CLR during calculation, late done ignored; then CLR with done together
    oper(2'b11); digit(9); oper(2'b00); digit(9);
    applyStimulus(0, 0, 1, 4'd0, 2'b00);
    oper(2'b11);
    sendDone(0, 0);
    compare("clr_calc_disp", disp_bcd, 0);
    digit(4); oper(2'b01); digit(8);
    applyStimulus(0, 0, 1, 4'd0, 2'b00);
    sendDone(0, 1);

    // Error path
    digit(3); oper(2'b10); digit(5);
    applyStimulus(0, 0, 1, 4'd0, 2'b00);
    sendDone(1, 0);
    digit(6);
    applyStimulus(0, 0, 1, 4'd0, 2'b00);
    oper(2'b11);
    compare("err_cleared", disp_err, 0);

    // Equals plus digit in S_B starts without shifting B
    digit(4); oper(2'b00); digit(5);
    applyStimulus(1, 0, 1, 4'd6, 2'b00);
    compare("combo_operand_b", operand_b, 16'h0005);
    sendDone(0, 0);

    // Randomized sequences
    for (int n = 0; n < 400; n++) begin
      if (phase == PH_WAIT && $urandom_range(0, 3) != 0)
        sendDone($urandom_range(0, 7) == 0, 0);
      else if ($urandom_range(0, 49) == 0)
        sendDone(0, 0);
      else
        randomKey();
    end

    // Asynchronous reset mid-calculation; late done must be ignored
    oper(2'b11); digit(2); oper(2'b00); digit(3);
    applyStimulus(0, 0, 1, 4'd0, 2'b00);
    #2 rst = 1'b1;
    modelReset();
    #4 rst = 1'b0;
    @(negedge clk);
    checkOutput();
    sendDone(0, 0);

    compare("scoreboard_empty", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/calc_ctrl.md
# calc_ctrl

Sequencing controller for the keypad calculator. It consumes the decoded key events produced by the keypad interface and builds two BCD operands and an operator from them. It issues a start/done handshake to the arithmetic unit, latches the result, and drives the display value. It sits between the keypad interface and the ALU/display path in `top`.

## Interface

Parameters:
- `NDIG`, default 4: maximum decimal digits per operand. The result is 2·NDIG digits.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `key_pulse`  in  1  one-cycle strobe per accepted key press; class flags and codes are sampled only when it is high.
- `number_pressed`  in  1  key is a digit.
- `operation_pressed`  in  1  key is an operator or clear.
- `equals_pressed`  in  1  key is equals.
- `digit_in`  in  4  digit value, 0–9; values 10–15 are ignored.
- `op_in`  in  2  operator code: 00 ADD, 01 SUB, 10 MUL, 11 CLR.
- `alu_done`  in  1  one-cycle completion strobe from the ALU.
- `alu_err`  in  1  error/overflow flag, valid with `alu_done`.
- `alu_neg`  in  1  result sign, valid with `alu_done`.
- `alu_result`  in  8·NDIG  BCD magnitude, valid with `alu_done`.
- `operand_a`, `operand_b`  out  4·NDIG  BCD operands, held stable while busy.
- `alu_op`  out  2  latched operator (never CLR).
- `alu_start`  out  1  one-cycle start pulse.
- `busy`  out  1  high while in S_CALC.
- `disp_bcd`  out  8·NDIG  value to display.
- `disp_neg`  out  1  sign to display.
- `disp_err`  out  1  error indicator.

## Operation

- Key class priority within one pulse: CLR, then equals, then operator, then digit. A pulse with no class flag is a no-op.
- CLR in any state clears A, B, op and result, goes to S_A, and drops any pending `alu_done`.
- Digit entry is a left shift: `X = {X[4·NDIG-5:0], d}`. Once NDIG digits have been entered, further digits are ignored (saturating).
- States and transitions:
  - S_A (reset state):
    - Digit shifts into A.
    - ADD, SUB or MUL latches `alu_op` and goes to S_OP.
    - Equals is ignored.
  - S_OP:
    - Digit sets B = d (count 1) and goes to S_B.
    - A further operator replaces `alu_op`.
    - Equals is ignored.
  - S_B:
    - Digit shifts into B.
    - Operator is ignored.
    - Equals pulses `alu_start` and goes to S_CALC.
  - S_CALC:
    - All keys except CLR are ignored.
    - `alu_done` with `alu_err`=0 latches result and sign, then goes to S_RES.
    - `alu_done` with `alu_err`=1 goes to S_ERR.
  - S_RES:
    - Digit sets A = d, B = 0, and goes to S_A.
    - Operator chains: A = low NDIG digits of the result, then op is latched and the state goes to S_OP. This only happens when the sign is 0 and the upper NDIG digits are zero; otherwise the operator is ignored.
    - Equals is ignored.
  - S_ERR: only CLR leaves this state.
- Display contents per state:
  - S_A and S_OP: A, zero-extended.
  - S_B and S_CALC: B.
  - S_RES: result and sign.
  - S_ERR: zeros with `disp_err`=1.
  - `disp_neg` is 0 in every state except S_RES.

## Timing

- Reset values:
  - State is S_A.
  - All outputs are 0.
- Every key effect is visible the cycle after the `key_pulse` cycle; all outputs are registered.
- `alu_start` is high for exactly the one cycle after equals is sampled in S_B. `busy` rises in that same cycle.
- `alu_done` is honoured only in S_CALC, from the cycle after `alu_start` onward. The result is visible on `disp_bcd` the cycle after `alu_done`.
- `operand_a`, `operand_b` and `alu_op` are constant from `alu_start` until the state leaves S_CALC.
- `key_pulse` and `alu_done` in the same cycle in S_CALC:
  - If the key is CLR, CLR wins and the result is discarded.
  - Otherwise `alu_done` is processed and the key is ignored.
- No timeout: S_CALC holds until `alu_done` or CLR.
- Asynchronous reset mid-calculation returns to S_A immediately. A late `alu_done` is then ignored.

## Structure

- Package `calc_pkg`:
  - Operator codes OP_ADD, OP_SUB, OP_MUL, OP_CLR.
  - State encoding S_A, S_OP, S_B, S_CALC, S_RES, S_ERR.
  - Default NDIG.
- Sub-module `bcd_entry_reg`:
  - Parameterised NDIG digit shift register with digit counter, saturation, clear and load-single-digit.
  - Instanced twice, for A and B.
  - A additionally supports a parallel load of the chained result.
- FSM, result latch and display mux live in `calc_ctrl`.

## Test plan

- 1, 2, ADD, 3, =:
  - `alu_start` is high one cycle, with `operand_a`=0x0012, `operand_b`=0x0003, `alu_op`=00.
  - `alu_done` with `alu_result`=0x00000015 gives `disp_bcd`=0x00000015 and S_RES.
- Digits 1, 2, 3, 4, 5 in S_A with NDIG=4 leave A = 0x1234 (fifth digit ignored). Equals in S_A produces no `alu_start`.
- 7, ADD, SUB, 2, = gives `alu_op`=01. An operator pressed in S_B does not change it.
- CLR while in S_CALC, followed by `alu_done` two cycles later:
  - State stays S_A, `disp_bcd`=0, `busy`=0.
  - CLR and `alu_done` in the same cycle also end in S_A.
- `alu_done` with `alu_err`=1 gives `disp_err`=1. Digits and equals are then ignored, and CLR returns to S_A with `disp_err`=0.
- Chaining from result 0x15: MUL, 2, = gives `operand_a`=0x0015, `operand_b`=0x0002, `alu_op`=10. A pulse with `equals_pressed` and `number_pressed` both high in S_B starts the ALU and does not shift B.
